// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
// State encoding and counter sizing used by serial_adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit-counter width: enough to index bits 0..width-1.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder, the only arithmetic cell of serial_adder.
// Ports: x, y, ci in; s (sum), co (carry-out) out. Purely combinational.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/sub, LSB first, one bit per clock, start/busy/done handshake.
// Ports: clk, rst (sync high), start, a, b, cin, sub in; busy, done, sum, cout, overflow out.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;

  logic fa_s;
  logic fa_co;
  logic accept;
  logic last;

  fa_cell u_fa (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign accept = start &
                  ((state == S_IDLE) |
                   (state == S_DONE));
  assign last   = (cnt == LAST);

  // New sum bit enters at the MSB; after WIDTH shifts
  // the register holds the result in natural order.
  assign res_nxt = {fa_s, {(WIDTH-1){1'b0}}}
                 | (res >> 1);

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN:  if (last)  state_nxt = S_DONE;
      S_DONE: state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1, with borrow-in
      // folded into the initial carry.
      a_sr  <= a;
      b_sr  <= b ^ {WIDTH{sub}};
      carry <= cin ^ sub;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      res   <= res_nxt;
      carry <= fa_co;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum      <= res_nxt;
        cout     <= fa_co;
        // carry is the carry into the MSB here.
        overflow <= carry ^ fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=2.
// Random and directed ops are checked against an arithmetic model.
module tb_serial_adder;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       sub8 = 1'b0;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;
  logic       ov8;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       cin2 = 1'b0;
  logic       sub2 = 1'b0;
  logic       busy2;
  logic       done2;
  logic [1:0] sum2;
  logic       cout2;
  logic       ov2;

  int checks = 0;
  int failures = 0;
  int done2_cnt = 0;
  int done8_cnt = 0;

  exp_t q8[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  always @(posedge clk) rst_q <= rst;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .start    (start8),
    .a        (a8),
    .b        (b8),
    .cin      (cin8),
    .sub      (sub8),
    .busy     (busy8),
    .done     (done8),
    .sum      (sum8),
    .cout     (cout8),
    .overflow (ov8)
  );

  serial_adder #(.WIDTH(2)) u_dut2 (
    .clk      (clk),
    .rst      (rst),
    .start    (start2),
    .a        (a2),
    .b        (b2),
    .cin      (cin2),
    .sub      (sub2),
    .busy     (busy2),
    .done     (done2),
    .sum      (sum2),
    .cout     (cout2),
    .overflow (ov2)
  );

  task automatic chk(input string name,
                     input longint unsigned act,
                     input longint unsigned req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h @%0t",
               name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input int w,
                                 input longint unsigned a,
                                 input longint unsigned b,
                                 input bit cin,
                                 input bit sub);
    exp_t e;
    longint unsigned m;
    longint unsigned full;
    longint sa, sb, r, hi, lo;
    m  = (64'd1 << w) - 1;
    hi = (64'sd1 <<< (w - 1)) - 1;
    lo = -(64'sd1 <<< (w - 1));
    sa = (a > longint'(hi)) ? longint'(a) - (64'sd1 <<< w) : longint'(a);
    sb = (b > longint'(hi)) ? longint'(b) - (64'sd1 <<< w) : longint'(b);
    if (!sub) begin
      full   = a + b + 64'(cin);
      e.sum  = full & m;
      e.cout = full[w];
      r      = sa + sb + 64'(cin);
    end else begin
      full   = a - b - 64'(cin);
      e.sum  = full & m;
      e.cout = (a >= b + 64'(cin));
      r      = sa - sb - 64'(cin);
    end
    e.ov = (r > hi) || (r < lo);
    return e;
  endfunction

  // Monitor for WIDTH=8: compare on done, otherwise outputs must hold.
  logic [7:0] p_sum8 = '0;
  logic       p_cout8 = 1'b0;
  logic       p_ov8 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      done8_cnt++;
      if (q8.size() == 0) begin
        chk("w8_unexpected_done", 1, 0);
      end else begin
        e = q8.pop_front();
        chk("w8_sum", sum8, e.sum);
        chk("w8_cout", cout8, e.cout);
        chk("w8_ovf", ov8, e.ov);
      end
    end else if (!rst_q) begin
      chk("w8_hold", {sum8, cout8, ov8}, {p_sum8, p_cout8, p_ov8});
    end
    p_sum8  = sum8;
    p_cout8 = cout8;
    p_ov8   = ov8;
  end

  logic [1:0] p_sum2 = '0;
  logic       p_cout2 = 1'b0;
  logic       p_ov2 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (done2) begin
      done2_cnt++;
      if (q2.size() == 0) begin
        chk("w2_unexpected_done", 1, 0);
      end else begin
        e = q2.pop_front();
        chk("w2_sum", sum2, e.sum);
        chk("w2_cout", cout2, e.cout);
        chk("w2_ovf", ov2, e.ov);
      end
    end else if (!rst_q) begin
      chk("w2_hold", {sum2, cout2, ov2}, {p_sum2, p_cout2, p_ov2});
    end
    p_sum2  = sum2;
    p_cout2 = cout2;
    p_ov2   = ov2;
  end

  // One WIDTH=8 op. b2b: caller sits at the DONE negedge, issue now.
  // inject: pulse start with other operands during RUN cycle 3.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input bit cin, input bit sub,
                      input bit inject, input bit b2b);
    int n;
    if (!b2b) @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
    q8.push_back(model(8, a, b, cin, sub));
    @(negedge clk);
    start8 = 1'b0;
    if (b2b) chk("w8_b2b_busy", busy8, 1);
    a8 = ~a; b8 = ~b; cin8 = ~cin; sub8 = ~sub;
    n = 0;
    while (busy8 && n < 40) begin
      n++;
      if (inject && n == 2) begin
        start8 = 1'b1;
        a8 = 8'h01; b8 = 8'h01;
      end
      if (inject && n == 3) start8 = 1'b0;
      @(negedge clk);
    end
    chk("w8_busy_len", n, 8);
    chk("w8_done_pulse", done8, 1);
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b,
                      input bit cin, input bit sub);
    int n;
    @(negedge clk);
    a2 = a; b2 = b; cin2 = cin; sub2 = sub; start2 = 1'b1;
    q2.push_back(model(2, a, b, cin, sub));
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (busy2 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("w2_busy_len", n, 2);
    chk("w2_done_pulse", done2, 1);
  endtask

  initial begin
    int d0;
    int n;
    repeat (2) @(negedge clk);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_out8", {sum8, cout8, ov8}, 0);
    chk("rst_out2", {busy2, done2, sum2, cout2, ov2}, 0);
    rst = 1'b0;

    run8(8'h5A, 8'h33, 0, 0, 0, 0);
    run8(8'hFF, 8'h01, 0, 0, 0, 0);
    run8(8'h10, 8'h20, 0, 1, 0, 0);
    run8(8'h80, 8'h01, 0, 1, 0, 0);
    run8(8'h7F, 8'h00, 1, 0, 0, 0);

    for (int i = 0; i < 64; i++)
      run2(i[5:4], i[3:2], i[1], i[0]);
    @(negedge clk);
    chk("w2_done_count", done2_cnt, 64);

    run8(8'h3C, 8'h4B, 1, 0, 1, 0);
    run8(8'hC3, 8'h2D, 0, 1, 0, 1);
    run8(8'h12, 8'h34, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++)
      run8(8'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom), 0,
           ($urandom_range(0, 3) == 0));

    // Abort mid-RUN with reset.
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 0; sub8 = 0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    d0 = done8_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_out", {sum8, cout8, ov8}, 0);
    n = 0;
    while (n < 12) begin
      n++;
      @(negedge clk);
    end
    chk("abort_no_done", done8_cnt, d0);
    run8(8'hAA, 8'h55, 1, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised bit-serial adder/subtractor that extends the single-bit full adder. It processes one bit per clock, LSB first, using one full-adder cell and a carry flip-flop. A start/busy/done handshake controls each operation. The block is the area-minimal arithmetic unit for multi-bit datapaths where a latency of WIDTH cycles is acceptable.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a new operation; sampled only when busy=0.
a  input  WIDTH  operand A, latched on accepted start.
b  input  WIDTH  operand B, latched on accepted start.
cin  input  1  carry-in (add) or borrow-in (sub), latched on accepted start.
sub  input  1  mode select: 0 = a+b+cin, 1 = a-b-cin; latched on accepted start.
busy  output  1  high while bits are being processed.
done  output  1  one-cycle pulse when the result registers update.
sum  output  WIDTH  result, held stable between completions.
cout  output  1  add: carry-out; sub: 1 = no borrow (a >= b+cin).
overflow  output  1  two's-complement signed overflow of the completed operation.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, carry FF=0, bit counter=0. rst has priority over all other inputs.
- States: IDLE, RUN, DONE.
- IDLE/DONE, start=1: latch a, b^{WIDTH{sub}}, carry FF = cin^sub, counter=0; go to RUN. A start in DONE is accepted, so back-to-back operations are allowed.
- DONE, start=0: go to IDLE.
- IDLE, start=0: stay in IDLE.
- RUN: each edge, the full-adder cell combines bit[0] of the A and B shift registers with the carry FF.
  - The sum bit is shifted into the MSB of the partial-result register.
  - A, B and the partial-result register shift right by 1.
  - The carry FF takes the cell's carry-out.
  - The counter increments.
  - On the edge that processes bit WIDTH-1:
    - sum takes the final partial-result value.
    - cout takes the cell's carry-out.
    - overflow takes (carry into MSB) XOR (carry out of MSB).
    - Next state is DONE.
- start during RUN is ignored. The latched operands are unaffected, and no queueing occurs.
- busy=1 exactly while state=RUN, i.e. WIDTH cycles.
- done=1 exactly while state=DONE, i.e. 1 cycle.
- Latency: start sampled at edge E0; the result is visible and done=1 after edge E(WIDTH). Throughput is one operation per WIDTH+1 cycles.
- sum, cout and overflow change only on the completion edge or on reset. They never show partial values.
- Changes to a, b, cin or sub after the accepted start have no effect on the current operation.
- Reset mid-RUN: the operation is aborted, done never pulses, and all outputs return to reset values.
- Arithmetic is modulo 2^WIDTH. Sub mode uses a + ~b + (1-cin).

Decomposition:
- Shared package serial_adder_pkg holds:
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - counter width function/constant CNT_W = $clog2(WIDTH).
- Sub-module fa_cell: a purely combinational 1-bit full adder (inputs x, y, ci; outputs s, co), instantiated once.
- The FSM, shift registers and result registers live in serial_adder.

Test Plan:
1. WIDTH=8, add, a=0x5A, b=0x33, cin=0 -> busy high 8 cycles, then done pulse with sum=0x8D, cout=0, overflow=1.
2. WIDTH=8, add, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0. Then sub, a=0x10, b=0x20, cin=0 -> sum=0xF0, cout=0, overflow=0.
3. WIDTH=8, sub, a=0x80, b=0x01, cin=0 -> sum=0x7F, cout=1, overflow=1. Then a+b+cin with a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, overflow=1.
4. WIDTH=2, exhaustive sweep of all a, b, cin, sub (64 ops) -> every result matches the reference model {cout,sum}. done pulses exactly once per op.
5. WIDTH=8: start during RUN cycle 3 with different operands -> ignored, first result unchanged. A start held high during the DONE cycle -> accepted, busy=1 on the next cycle.
6. WIDTH=8, rst=1 at RUN cycle 4 after a=0xAA, b=0x55 -> next cycle busy=0, sum=0, cout=0, overflow=0, and no done pulse. A subsequent op completes normally.
